// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit seven-segment scan driver.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEL_W      = 2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry F first so index n selects hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
    } disp_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    assign seg_c = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with double-buffered data.
// Optional anti-ghosting blank interval at the start of each slot: SEG7_GHOST_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp_in,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
`ifdef SEG7_GHOST_BLANK_EN
    localparam bit GHOST_BLANK = 1'b1;
`else
    localparam bit GHOST_BLANK = 1'b0;
`endif

    logic [CNT_W-1:0] cnt;
    disp_t            stage_q;
    disp_t            disp_q;
    logic             pending_q;

    logic             wrap_c;
    logic             boundary_c;
    logic             last_c;
    logic             blank_c;
    disp_t            load_c;
    logic [3:0]       nibble_c;
    logic [6:0]       seg_c;
    logic [3:0]       an_c;

    assign wrap_c     = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign boundary_c = wrap_c && (sel == 2'd3);
    // One cycle before the frame's final cycle, so frame_tick lands on the 3->0 cycle.
    assign last_c     = (cnt == CNT_W'(REFRESH_DIV - 2)) && (sel == 2'd3);
    assign blank_c    = GHOST_BLANK && (cnt < CNT_W'(BLANK_CYCLES));
    assign load_c     = '{value: value, dp: dp_in};
    assign nibble_c   = disp_q.value[{sel, 2'b00} +: 4];
    assign an_c       = digit_en[sel] ? (ANODE_OFF & ~(4'(4'b0001 << sel))) : ANODE_OFF;

    hex_to_seg7 u_hex (
        .nibble (nibble_c),
        .seg_c  (seg_c)
    );

    // Prescaler, digit select, double buffer and registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sel        <= '0;
            frame_tick <= 1'b0;
            stage_q    <= '0;
            disp_q     <= '0;
            pending_q  <= 1'b0;
            an         <= ANODE_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
        end else begin
            cnt        <= wrap_c ? '0 : cnt + CNT_W'(1);
            frame_tick <= last_c;
            if (wrap_c) begin
                sel <= sel + 2'd1;
            end

            if (load && boundary_c) begin
                disp_q    <= load_c;
                pending_q <= 1'b0;
            end else if (load) begin
                stage_q   <= load_c;
                pending_q <= 1'b1;
            end else if (boundary_c && pending_q) begin
                disp_q    <= stage_q;
                pending_q <= 1'b0;
            end

            an  <= blank_c ? ANODE_OFF : an_c;
            seg <= blank_c ? SEG_BLANK : seg_c;
            dp  <= ~disp_q.dp[sel];
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (REFRESH_DIV=4, BLANK_CYCLES=2).
module tb_seg7_scan_driver;

    localparam int DIV   = 4;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;
`ifdef SEG7_GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .sel        (sel),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: the display in frame f is the most recent load made before frame f began.
    int          ld_cyc [$];
    logic [15:0] ld_val [$];
    logic [3:0]  ld_dp  [$];

    task automatic disp_at(input int frame, output logic [15:0] v, output logic [3:0] d);
        v = '0;
        d = '0;
        foreach (ld_cyc[i]) begin
            if (ld_cyc[i] < frame * FRAME) begin
                v = ld_val[i];
                d = ld_dp[i];
            end
        end
    endtask

    int          k = 0;
    int          s;
    bit          have_exp = 1'b0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [15:0] m_v;
    logic [3:0]  m_d;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_sel", 32'(sel), 32'd0);
            chk("rst_frame_tick", 32'(frame_tick), 32'd0);
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_dp", 32'(dp), 32'd1);
            k = 0;
            have_exp = 1'b0;
            ld_cyc.delete();
            ld_val.delete();
            ld_dp.delete();
        end else begin
            chk("sel", 32'(sel), 32'((k / DIV) % 4));
            chk("frame_tick", 32'(frame_tick), 32'((k % FRAME) == FRAME - 1));
            if (have_exp) begin
                chk("an", 32'(an), 32'(e_an));
                chk("seg", 32'(seg), 32'(e_seg));
                chk("dp", 32'(dp), 32'(e_dp));
            end else begin
                chk("an_pre", 32'(an), 32'hF);
                chk("seg_pre", 32'(seg), 32'h7F);
                chk("dp_pre", 32'(dp), 32'd1);
            end
            if (load) begin
                ld_cyc.push_back(k);
                ld_val.push_back(value);
                ld_dp.push_back(dp_in);
            end
            s = (k / DIV) % 4;
            disp_at(k / FRAME, m_v, m_d);
            e_seg = hex7[m_v[4*s +: 4]];
            e_an  = digit_en[s] ? (4'hF & ~(4'(4'b0001 << s))) : 4'hF;
            e_dp  = ~m_d[s];
            if (GHOST && (k % DIV) < BLANK) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
            end
            have_exp = 1'b1;
            k++;
        end
    end

    int tc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        tc++;
    endtask

    task automatic goto(input int j);
        while (tc < j) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value   = v;
        dp_in   = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        digit_en = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_seg", 32'(seg), 32'h7F);
        chk("lit_rst_an", 32'(an), 32'hF);
        rst_n = 1'b1;
        tc    = 0;
        chk("lit_pre_update_an", 32'(an), 32'hF);
        tick();
        chk("lit_first_an", 32'(an), GHOST ? 32'hF : 32'hE);
        goto(14); chk("lit_ft_14", 32'(frame_tick), 32'd0);
        goto(15); chk("lit_ft_15", 32'(frame_tick), 32'd1);

        goto(20); do_load(16'h1234, 4'b0100);
        goto(24); chk("lit_no_tear", 32'(seg), 32'h40);
        goto(36); chk("lit_1234_d0", 32'(seg), 32'h19);
        goto(40); chk("lit_1234_d1", 32'(seg), 32'h30);
        goto(44); chk("lit_1234_d2", 32'(seg), 32'h24);
        chk("lit_1234_an2", 32'(an), 32'hB);
        chk("lit_1234_dp2", 32'(dp), 32'd0);
        goto(48); chk("lit_1234_d3", 32'(seg), 32'h79);
        chk("lit_1234_dp3", 32'(dp), 32'd1);

        goto(50); do_load(16'hAAAA, 4'b0000);
        goto(52); do_load(16'hBEEF, 4'b0000);
        goto(68); chk("lit_beef_d0", 32'(seg), 32'h0E);
        goto(70); do_load(16'h5555, 4'b0000);
        goto(79); chk("lit_ft_79", 32'(frame_tick), 32'd1);
        do_load(16'h0F0F, 4'b0000);
        chk("lit_beef_d3", 32'(seg), 32'h03);
        goto(84); chk("lit_0f0f_d0", 32'(seg), 32'h0E);
        goto(88); chk("lit_0f0f_d1", 32'(seg), 32'h40);

        goto(96);  digit_en = 4'b0101;
        goto(100); chk("lit_keep_0f0f", 32'(seg), 32'h0E);
        goto(104); chk("lit_en_off_an", 32'(an), 32'hF);
        chk("lit_en_off_seg", 32'(seg), 32'h40);
        goto(108); chk("lit_en_on_an", 32'(an), 32'hB);

        goto(114); do_load(16'h1111, 4'b1111);
        goto(118);
        rst_n = 1'b0;
        #1;
        chk("lit_midrst_an", 32'(an), 32'hF);
        chk("lit_midrst_seg", 32'(seg), 32'h7F);
        chk("lit_midrst_sel", 32'(sel), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tc    = 0;
        goto(20); chk("lit_post_rst_d0", 32'(seg), 32'h40);
        goto(36); chk("lit_staged_lost", 32'(seg), 32'h40);
        goto(40); chk("lit_post_rst_an1", 32'(an), 32'hF);

        n = 0;
        while (frame_tick !== 1'b1 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        chk("wait_frame_tick", 32'(frame_tick), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
